// File: rtl/adc_stream_packetizer.sv
// adc_stream_packetizer
// Packs pairs of 16-bit ADC samples into 32-bit AXI4-Stream beats for the DMA S2MM port.
// A start pulse latches the packet length. Completed words go through a FWFT FIFO with a
// registered output stage. The final word carries a tlast tag.
//
// Ports:
//   clk, resetn      system clock, asynchronous active-low reset
//   start            capture request pulse (ignored while busy)
//   pkt_size         packet length in bytes; bits [1:0] ignored
//   adc_data/valid   sample input, no backpressure
//   m_axis_*         AXI4-Stream master (tdata/tvalid/tready/tlast)
//   busy             capture or drain in progress
//   done             one-cycle pulse when the last beat handshakes (or after a zero-length start)
//   overflow         sticky: at least one completed word was dropped on a full FIFO
module adc_stream_packetizer #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned SIZE_W     = 26
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [SIZE_W-1:0] pkt_size,
    input  logic [15:0]       adc_data,
    input  logic              adc_valid,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned WW = SIZE_W - 2;
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [WW-1:0] WordOne = 1;

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   words_q, words_d;
    logic            phase_q, phase_d;
    logic [15:0]     held_q, held_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [32:0]     mem [FIFO_DEPTH];
    logic            out_valid_q, out_last_q;
    logic [31:0]     out_data_q;

    logic            fifo_empty, fifo_full, pop, last_hs;
    logic            wr_en, wr_last;
    logic [WW-1:0]   size_words;

    logic            unused_size;
    assign unused_size = ^pkt_size[1:0];

    assign size_words = pkt_size[SIZE_W-1:2];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign pop        = !fifo_empty && (!out_valid_q || m_axis_tready);
    assign last_hs    = out_valid_q && m_axis_tready && out_last_q;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        phase_d = phase_q;
        held_d  = held_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    words_d = size_words;
                    ovf_d   = 1'b0;
                    phase_d = 1'b0;
                    if (size_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (adc_valid) begin
                    if (!phase_q) begin
                        held_d  = adc_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // A pop on the same edge frees a slot, so a full FIFO can still accept.
                        if (!fifo_full || pop) begin
                            wr_en   = 1'b1;
                            words_d = words_q - WordOne;
                            if (words_q == WordOne) begin
                                wr_last = 1'b1;
                                state_d = StDrain;
                            end
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                if (last_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            words_q <= '0;
            phase_q <= 1'b0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            phase_q <= phase_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Storage array is not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {wr_last, adc_data, held_q};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q                 <= rd_ptr_q + PtrOne;
                {out_last_q, out_data_q} <= mem[rd_ptr_q[AW-1:0]];
                out_valid_q              <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q || (last_hs && (state_q == StDrain));
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_adc_stream_packetizer.sv
module tb_adc_stream_packetizer;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned SIZE_W     = 26;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [SIZE_W-1:0] pkt_size = '0;
    logic [15:0]       adc_data = '0;
    logic              adc_valid = 1'b0;
    logic [31:0]       tdata;
    logic              tvalid;
    logic              tready = 1'b0;
    logic              tlast;
    logic              busy;
    logic              done;
    logic              overflow;

    adc_stream_packetizer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .SIZE_W    (SIZE_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .pkt_size     (pkt_size),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records handshaken beats, counts done/valid/busy, checks stall stability.
    logic [32:0] beats[$];
    int          done_cnt = 0;
    int          valid_seen = 0;
    int          busy_seen = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (prev_stall) begin
                check("stall_valid", 64'(tvalid), 64'd1);
                check("stall_hold", 64'({tlast, tdata}), 64'(prev_beat));
            end
            if (tvalid && tready) beats.push_back({tlast, tdata});
            if (tvalid) valid_seen++;
            if (done) done_cnt++;
            if (busy) busy_seen++;
            prev_stall = tvalid && !tready;
            prev_beat  = {tlast, tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int samp = 0;
    int base = 0;

    // rmode: 0 tready=1, 1 random 50%, 2 low for the first 200 cycles.
    task automatic run_packet(input int size, input int vper, input int rmode,
                              input int restart_at, input int rst_beat);
        bit finished;
        finished   = 1'b0;
        beats.delete();
        done_cnt   = 0;
        valid_seen = 0;
        busy_seen  = 0;
        pkt_size   = SIZE_W'(size);
        start      = 1'b1;
        tick();
        start = 1'b0;
        base  = samp;
        for (int c = 0; c < 8000; c++) begin
            if (rst_beat > 0 && beats.size() >= rst_beat) begin
                resetn    = 1'b0;
                adc_valid = 1'b0;
                #1;
                check("rst_tvalid", 64'(tvalid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_overflow", 64'(overflow), 64'd0);
                tick();
                check("rst_tvalid_hold", 64'(tvalid), 64'd0);
                resetn = 1'b1;
                tready = 1'b1;
                tick();
                return;
            end
            adc_valid = ((c % vper) == 0);
            if (adc_valid) begin
                adc_data = samp[15:0];
                samp++;
            end
            case (rmode)
                0:       tready = 1'b1;
                1:       tready = 1'($urandom_range(0, 1));
                default: tready = (c >= 200);
            endcase
            start = (c == restart_at);
            tick();
            if (done_cnt > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        adc_valid = 1'b0;
        start     = 1'b0;
        tready    = 1'b1;
        check("timeout", 64'(finished), 64'd1);
        repeat (4) tick();
    endtask

    task automatic check_beats(input int n, input int b, input int nchk);
        logic [32:0] exp;
        check("beat_count", 64'(beats.size()), 64'(n));
        for (int k = 0; k < beats.size(); k++) begin
            if (k < nchk) begin
                exp = {(k == n - 1), 16'(b + 2 * k + 1), 16'(b + 2 * k)};
                check($sformatf("beat%0d", k), 64'(beats[k]), 64'(exp));
            end else begin
                check($sformatf("tlast%0d", k), 64'(beats[k][32]), 64'(k == n - 1));
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset_tvalid", 64'(tvalid), 64'd0);
        check("reset_tlast", 64'(tlast), 64'd0);
        check("reset_tdata", 64'(tdata), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;
        tready = 1'b1;
        repeat (2) tick();

        // Basic 512-beat packet.
        samp = 0;
        run_packet(2048, 1, 0, -1, 0);
        check_beats(512, 0, 512);
        check("basic_done", 64'(done_cnt), 64'd1);
        check("basic_ovf", 64'(overflow), 64'd0);
        check("basic_busy", 64'(busy), 64'd0);

        // Random backpressure, sparse samples.
        samp = 0;
        run_packet(2048, 4, 1, -1, 0);
        check_beats(512, 0, 512);
        check("bp_done", 64'(done_cnt), 64'd1);
        check("bp_ovf", 64'(overflow), 64'd0);

        // Overflow while the sink is stalled.
        samp = 0;
        run_packet(256, 1, 2, -1, 0);
        check_beats(64, 0, 16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_done", 64'(done_cnt), 64'd1);

        // Zero-length packet: done on the following cycle, never busy.
        done_cnt   = 0;
        valid_seen = 0;
        busy_seen  = 0;
        pkt_size   = '0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_ovf_clr", 64'(overflow), 64'd0);
        tick();
        check("zero_done_pulse", 64'(done), 64'd0);
        repeat (3) tick();
        check("zero_done_cnt", 64'(done_cnt), 64'd1);
        check("zero_valid", 64'(valid_seen), 64'd0);
        check("zero_busy_seen", 64'(busy_seen), 64'd0);

        // pkt_size=6 rounds down to one word.
        samp = 0;
        run_packet(6, 1, 0, -1, 0);
        check_beats(1, 0, 1);
        check("six_done", 64'(done_cnt), 64'd1);

        // Second start during capture is ignored.
        samp = 0;
        run_packet(64, 1, 0, 10, 0);
        check_beats(16, 0, 16);
        check("restart_done", 64'(done_cnt), 64'd1);

        // Reset mid-packet, then a fresh short packet.
        samp = 0;
        run_packet(2048, 1, 0, -1, 100);
        repeat (2) tick();
        run_packet(16, 1, 0, -1, 0);
        check_beats(4, base, 4);
        check("post_rst_done", 64'(done_cnt), 64'd1);
        check("post_rst_ovf", 64'(overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_stream_packetizer.md
Name: adc_stream_packetizer

Overview:
- Sits between the ADC capture front end (deserialized 16-bit samples, system clock domain) and the AXI DMA S2MM stream port of the digitizer.
- On a software start it captures a programmed number of bytes and packs sample pairs into 32-bit AXI4-Stream beats.
- Buffers beats in an internal FIFO and marks the last beat with tlast so the DMA closes the transfer.

Parameters:
- FIFO_DEPTH, 64, output FIFO depth in 32-bit words (power of 2, >= 4).
- SIZE_W, 26, width of the packet-size field in bytes (covers a 32 MiB DMA buffer).

Ports:
- clk  in  1  system clock; all logic is in this one clock domain.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  capture request pulse from the register block (offset 0x0, bit 0).
- pkt_size  in  SIZE_W  packet length in bytes (offset 0x8). Bits [1:0] are ignored.
- adc_data  in  16  captured ADC sample.
- adc_valid  in  1  adc_data is valid this cycle. There is no backpressure toward the ADC.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the DMA.
- m_axis_tlast  out  1  final beat of the packet.
- busy  out  1  a capture or drain is in progress.
- done  out  1  one-cycle pulse when the last beat handshakes.
- overflow  out  1  sticky flag: at least one word was dropped.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, overflow=0. Reset also flushes the FIFO, clears the counters and returns the FSM to IDLE. Reset mid-packet abandons the packet; no tlast is emitted.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start=1 latches words = pkt_size[SIZE_W-1:2], clears overflow, clears the pack phase, and sets busy on the next edge.
  - If words==0: no state change, busy stays 0, and done pulses on the cycle after start.
  - Otherwise go to CAPTURE.
  - adc_valid is ignored in IDLE.
- CAPTURE:
  - Packing starts with the first adc_valid after entry. An even-phase sample is held in the low half. The next valid sample completes the word {adc_data, held} (earlier sample in bits [15:0], little-endian order in memory).
  - A completed word is written to the FIFO on the same edge that accepts the second sample.
  - If the FIFO is full on that edge, the word is dropped, overflow is set, and the word counter does not advance. The packet is therefore always exactly `words` beats long.
  - The counter of accepted words decrements per write. The write that brings it to 0 carries a tlast tag bit stored in the FIFO, and the FSM goes to DRAIN.
- DRAIN:
  - No further samples are accepted.
  - When the tlast beat handshakes (tvalid & tready & tlast): done=1 for that cycle, busy falls on the following edge, and the FSM returns to IDLE.
- start while busy (CAPTURE or DRAIN) is ignored.
- FIFO: first-word-fall-through with a registered output stage.
  - Latency: word write at edge E gives tvalid=1 after edge E+1 when the FIFO was empty.
  - Sustained throughput: 1 beat/cycle when tready=1. Input rate is at most 1 word per 2 cycles.
  - Simultaneous read and write on a full FIFO is allowed: the write succeeds and no overflow is flagged.
- AXI rules:
  - tdata, tlast and tvalid are held stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.
  - tlast is asserted only on the final beat.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a pointer width of log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Basic packet: ramp samples 0,1,2,… with adc_valid every cycle, pkt_size=2048, tready=1 → 512 beats, beat k = {16'(2k+1), 16'(2k)}, tlast only on beat 511, exactly one done pulse, overflow=0, busy low afterwards.
- Backpressure: same stimulus with tready toggling pseudo-randomly at 50% and adc_valid every 4th cycle → identical 512-beat sequence, data stable during stalls, overflow=0.
- Overflow: FIFO_DEPTH=16, tready=0 for the first 200 cycles, adc_valid every cycle, pkt_size=256 → overflow=1, still exactly 64 beats delivered with tlast on the 64th, and the first 16 beats are {1,0}..{31,30}.
- Size edge cases:
  - pkt_size=0 → done pulse on the cycle after start, no tvalid, busy stays 0.
  - pkt_size=6 → exactly 1 beat {1,0} with tlast.
- Start while busy: second start pulse mid-capture (pkt_size=64) → ignored, exactly 16 beats and one done pulse.
- Reset mid-packet: resetn low after beat 100 of 512 → tvalid, busy and overflow read 0 during reset. A new start with pkt_size=16 then yields 4 fresh beats starting from the current sample pair, with no stale FIFO data.
